gobou_core_vec: RTL and testbench

Parametrised successor to the single-lane fully-connected core: LANES parallel MAC lanes share one streamed input pixel, each with its own weight. Each lane accumulates a dot product at full precision, adds a per-lane bias, rescales the fixed-point result, saturates it and optionally applies ReLU. Input and output use valid/ready handshakes. The block sits between the FC-layer input/weight buffers and the output write-back path.

---
 rtl/gobou_pkg.sv | 34 +++
 rtl/gobou_lane.sv | 74 +++++++
 rtl/gobou_core_vec.sv | 95 +++++++++
 tb/tb_gobou_core_vec.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gobou_pkg.sv
// Shared types and helpers for the gobou vector FC core.
// State encoding, default widths and the saturation helper.
package gobou_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    OUT    = 2'd2
  } state_e;

  localparam int DWIDTH_DEF = 16;
  localparam int FRAC_DEF   = 8;
  localparam int AWIDTH_DEF = 40;

  // Wide working width for the clamp; lanes sign-extend into it.
  localparam int SAT_W = 64;

  // Clamp a wide signed value into the dw-bit signed range.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] t,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (t > hi)
      return hi;
    else if (t < lo)
      return lo;
    return t;
  endfunction

endpackage

// File: rtl/gobou_lane.sv
// One MAC lane: accumulator, bias register and the
// rescale / saturate / ReLU output path.
module gobou_lane
  import gobou_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_en_i,
  input  logic              clr_i,
  input  logic              fin_i,
  input  logic              relu_i,
  input  logic              breg_we_i,
  input  logic [DWIDTH-1:0] pixel_i,
  input  logic [DWIDTH-1:0] weight_i,
  input  logic [DWIDTH-1:0] bias_i,
  output logic [DWIDTH-1:0] result_o
);

  logic signed [AWIDTH-1:0]   acc_q, acc_d;
  logic signed [DWIDTH-1:0]   bias_q;
  logic        [DWIDTH-1:0]   res_q, res_d;
  logic signed [2*DWIDTH-1:0] prod;
  logic signed [AWIDTH-1:0]   prod_ext;
  logic signed [AWIDTH-1:0]   bias_sh;
  logic signed [AWIDTH-1:0]   s;
  logic signed [AWIDTH-1:0]   t;
  logic signed [SAT_W-1:0]    t_wide;
  logic        [DWIDTH-1:0]   sat;

  assign prod     = $signed(pixel_i) * $signed(weight_i);
  assign prod_ext = AWIDTH'(prod);
  assign bias_sh  = AWIDTH'(bias_q) <<< FRAC;
  assign s        = acc_q + bias_sh;
  assign t        = s >>> FRAC;
  assign t_wide   = SAT_W'(t);
  assign sat      = DWIDTH'(saturate(t_wide, DWIDTH));

  // Accumulate on accepted beats, clear after the output handshake.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (acc_en_i)
      acc_d = acc_q + prod_ext;
  end

  // Capture the rescaled, clamped, optionally rectified result.
  always_comb begin
    res_d = res_q;
    if (fin_i)
      res_d = (relu_i && sat[DWIDTH-1]) ? '0 : sat;
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      bias_q <= '0;
      res_q  <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      if (breg_we_i)
        bias_q <= bias_i;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/gobou_core_vec.sv
// Multi-lane FC core: shared pixel stream, per-lane weights,
// FSM sequencing accumulate, finish and output handshake.
module gobou_core_vec
  import gobou_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LANES  = 8,
  parameter int FRAC   = FRAC_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    xrst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [DWIDTH-1:0]       pixel,
  input  logic [LANES*DWIDTH-1:0] weight,
  input  logic                    breg_we,
  input  logic [LANES*DWIDTH-1:0] bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DWIDTH-1:0] result
);

  state_e state_q, state_d;
  logic   ov_q, ov_d;
  logic   acc_en;
  logic   fin;
  logic   clr;

  assign in_ready  = (state_q == ACCUM);
  assign acc_en    = in_valid && in_ready;
  assign fin       = (state_q == FINISH);
  assign clr       = (state_q == OUT) && out_ready;
  assign out_valid = ov_q;

  // Next-state and output-valid decode.
  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    case (state_q)
      ACCUM: begin
        if (acc_en && in_last)
          state_d = FINISH;
      end
      FINISH: begin
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        ov_d    = 1'b0;
        state_d = ACCUM;
      end
    endcase
  end

  // FSM state and output-valid registers.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q <= ACCUM;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gobou_lane #(
      .DWIDTH (DWIDTH),
      .FRAC   (FRAC),
      .AWIDTH (AWIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (xrst),
      .acc_en_i  (acc_en),
      .clr_i     (clr),
      .fin_i     (fin),
      .relu_i    (relu_en),
      .breg_we_i (breg_we),
      .pixel_i   (pixel),
      .weight_i  (weight[i*DWIDTH +: DWIDTH]),
      .bias_i    (bias[i*DWIDTH +: DWIDTH]),
      .result_o  (result[i*DWIDTH +: DWIDTH])
    );
  end

endmodule

// File: tb/tb_gobou_core_vec.sv
// Self-checking bench for gobou_core_vec (4 lanes).
// Directed cases plus random vectors against a plain-arithmetic model.
module tb_gobou_core_vec;

  localparam int L  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          xrst;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] pixel;
  logic [L*DW-1:0] weight;
  logic          breg_we;
  logic [L*DW-1:0] bias;
  logic          relu_en;
  logic          out_valid;
  logic          out_ready;
  logic [L*DW-1:0] result;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] px_a[8];
  logic signed [15:0] wt_a[8][L];
  logic signed [15:0] bcur[L];
  logic signed [15:0] bnext[L];

  always #5 clk = ~clk;

  gobou_core_vec #(
    .DWIDTH (DW),
    .LANES  (L),
    .FRAC   (8),
    .AWIDTH (40)
  ) dut (
    .clk       (clk),
    .xrst      (xrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .pixel     (pixel),
    .weight    (weight),
    .breg_we   (breg_we),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Dot product, bias, floor shift, clamp, ReLU; 40-bit wrap.
  function automatic logic [15:0] model(input int l, input int n,
                                        input bit relu);
    longint s;
    longint t;
    s = 0;
    for (int k = 0; k < n; k++)
      s += longint'(px_a[k]) * longint'(wt_a[k][l]);
    s += longint'(bcur[l]) * 256;
    s = (s <<< 24) >>> 24;
    t = s >>> 8;
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
    if (relu && t < 0) t = 0;
    return 16'(t);
  endfunction

  function automatic logic [15:0] lane_res(input int l);
    return result[l*DW +: DW];
  endfunction

  task automatic load_bias();
    @(negedge clk);
    breg_we = 1'b1;
    for (int l = 0; l < L; l++) begin
      bias[l*DW +: DW] = bnext[l];
      bcur[l] = bnext[l];
    end
    @(negedge clk);
    breg_we = 1'b0;
  endtask

  task automatic fill(input int n, input logic signed [15:0] p,
                      input logic signed [15:0] w);
    for (int k = 0; k < n; k++) begin
      px_a[k] = p;
      for (int l = 0; l < L; l++) wt_a[k][l] = w;
    end
  endtask

  task automatic drive_beat(input int b, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    pixel    = px_a[b];
    for (int l = 0; l < L; l++) weight[l*DW +: DW] = wt_a[b][l];
  endtask

  // Run one vector, check latency, result and handshake.
  task automatic do_vec(input string nm, input int n, input bit relu,
                        input bit wr_fin, input bit bp,
                        input bit use_k, input logic [15:0] k);
    logic [15:0] exp_r[L];
    relu_en = relu;
    for (int l = 0; l < L; l++) exp_r[l] = model(l, n, relu);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      check({nm, ".rdy"}, 64'(in_ready), 64'd1);
      drive_beat(b, b == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({nm, ".ov_fin"}, 64'(out_valid), 64'd0);
    check({nm, ".rdy_fin"}, 64'(in_ready), 64'd0);
    if (wr_fin) begin
      breg_we = 1'b1;
      for (int l = 0; l < L; l++) begin
        bnext[l] = 16'($urandom_range(0, 65535));
        bias[l*DW +: DW] = bnext[l];
        bcur[l] = bnext[l];
      end
    end
    @(negedge clk);
    breg_we = 1'b0;
    check({nm, ".ov"}, 64'(out_valid), 64'd1);
    for (int l = 0; l < L; l++)
      check($sformatf("%s.res%0d", nm, l), 64'(lane_res(l)),
            64'(exp_r[l]));
    if (use_k)
      check({nm, ".const"}, 64'(lane_res(0)), 64'(k));
    if (bp) begin
      for (int c = 0; c < 5; c++) begin
        in_valid = 1'b1;
        in_last  = c[0];
        pixel    = 16'($urandom);
        weight   = {L{16'($urandom)}};
        @(negedge clk);
        check({nm, ".bp_rdy"}, 64'(in_ready), 64'd0);
        check({nm, ".bp_ov"}, 64'(out_valid), 64'd1);
        check({nm, ".bp_res"}, 64'(lane_res(L - 1)),
              64'(exp_r[L - 1]));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, ".ov_clr"}, 64'(out_valid), 64'd0);
    check({nm, ".rdy_ret"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    xrst      = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    pixel     = '0;
    weight    = '0;
    breg_we   = 1'b0;
    bias      = '0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    for (int l = 0; l < L; l++) bcur[l] = '0;
    #1;
    check("rst.ov", 64'(out_valid), 64'd0);
    check("rst.res", 64'(result), 64'd0);
    check("rst.rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    xrst = 1'b0;

    fill(3, 16'sd256, 16'sd512);
    do_vec("basic", 3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1536);

    for (int l = 0; l < L; l++) bnext[l] = 16'sd256;
    load_bias();
    do_vec("bias", 3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1792);
    for (int l = 0; l < L; l++) bnext[l] = '0;
    load_bias();

    fill(3, 16'sd256, -16'sd512);
    do_vec("relu1", 3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    do_vec("relu0", 3, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFA00);

    fill(4, 16'sd32767, 16'sd32767);
    do_vec("satp", 4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF);
    fill(4, 16'sd32767, -16'sd32767);
    do_vec("satn", 4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000);

    fill(2, 16'sd100, 16'sd300);
    do_vec("bp", 2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    fill(1, 16'sd256, 16'sd256);
    do_vec("bp_next", 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd256);

    fill(3, 16'sd256, 16'sd512);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive_beat(b, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    xrst     = 1'b1;
    #1;
    check("mrst.ov", 64'(out_valid), 64'd0);
    check("mrst.res", 64'(result), 64'd0);
    check("mrst.rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    xrst = 1'b0;
    for (int l = 0; l < L; l++) bcur[l] = '0;
    fill(1, 16'sd256, 16'sd512);
    do_vec("mrst_next", 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd512);

    for (int v = 0; v < 25; v++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        px_a[k] = 16'($urandom);
        for (int l = 0; l < L; l++) wt_a[k][l] = 16'($urandom);
        if (v % 3 == 0) px_a[k] = 16'($urandom_range(0, 511));
      end
      if (v % 5 == 1) begin
        for (int l = 0; l < L; l++)
          bnext[l] = 16'($urandom);
        load_bias();
      end
      do_vec($sformatf("rnd%0d", v), n, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), v % 7 == 3, 1'b0, 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
